anita_prog_trigger_map: RTL and testbench

- Parametrised successor of the fixed ANITA3 SURF-to-phi L1 trigger map.
- Routes each of the 2*NUM_PHI phi-sector trigger outputs (V pol, then H pol) from a run-time programmable source bit of the flat SURF L1 bus.
- Applies the per-sector mask, then stretches each hit by a programmable number of cycles.
- Sits between the SURF L1 input capture and the TURF phi-coincidence logic. All logic runs on the 250 MHz trigger clock.

---
 rtl/anita_prog_trigger_map.sv | 82 ++++++++
 tb/tb_anita_prog_trigger_map.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/anita_prog_trigger_map.sv
// anita_prog_trigger_map: programmable SURF L1 to phi-sector trigger router with per-sector mask and retriggerable stretch
module anita_prog_trigger_map #(
   parameter int NUM_SURFS    = 12,
   parameter int NUM_TRIG     = 4,
   parameter int NUM_PHI      = 16,
   parameter int SEL_BITS     = 6,
   parameter int ADDR_BITS    = 5,
   parameter int STRETCH_BITS = 3
) (
   input  logic                          clk250_i,
   input  logic                          rst_i,
   input  logic [NUM_SURFS*NUM_TRIG-1:0] L1_i,
   input  logic [2*NUM_PHI-1:0]          mask_i,
   input  logic [STRETCH_BITS-1:0]       stretch_i,
   input  logic                          map_wr_i,
   input  logic [ADDR_BITS-1:0]          map_addr_i,
   input  logic [SEL_BITS-1:0]           map_data_i,
   output logic [SEL_BITS-1:0]           map_rdata_o,
   output logic [NUM_PHI-1:0]            V_pol_phi_o,
   output logic [NUM_PHI-1:0]            H_pol_phi_o
);
   localparam int NOUT = 2*NUM_PHI;
   localparam int AW   = $clog2(NOUT);
   localparam int L1W  = 2**SEL_BITS;
   logic [SEL_BITS-1:0]     map_q [NOUT];
   logic [SEL_BITS-1:0]     map_rdata_q;
   logic [STRETCH_BITS-1:0] cnt_q [NOUT];
   logic [STRETCH_BITS-1:0] cnt_d [NOUT];
   logic [NOUT-1:0]         s1_q, s1_d, out_q, out_d;
   // zero-extended to the full select range so out-of-range sources read a constant 0
   logic [L1W-1:0]          l1_ext;
   logic                    addr_ok;
   logic [AW-1:0]           addr;

   function automatic logic [SEL_BITS-1:0] def_entry(int k);
      int p;
      p = k % NUM_PHI;
      return SEL_BITS'(NUM_TRIG*(p/2+2) + p%2 + (k >= NUM_PHI ? 2 : 0));
   endfunction

   assign l1_ext      = L1W'(L1_i);
   assign addr_ok     = 32'(map_addr_i) < NOUT;
   assign addr        = map_addr_i[AW-1:0];
   assign map_rdata_o = map_rdata_q;
   assign V_pol_phi_o = out_q[NUM_PHI-1:0];
   assign H_pol_phi_o = out_q[NOUT-1:NUM_PHI];

   // next state: masked source selection for stage 1, reload-or-count-down stretch for stage 2
   always_comb begin
      s1_d  = '0;
      out_d = '0;
      for (int k = 0; k < NOUT; k++) begin
         s1_d[k]  = ~mask_i[k] & l1_ext[map_q[k]];
         out_d[k] = s1_q[k] | (cnt_q[k] != '0);
         cnt_d[k] = s1_q[k] ? stretch_i : cnt_q[k] - STRETCH_BITS'(cnt_q[k] != '0);
      end
   end

   // two-stage trigger pipeline; reset truncates any running stretch
   always_ff @(posedge clk250_i) begin
      if (rst_i) begin
         s1_q  <= '0;
         out_q <= '0;
         for (int k = 0; k < NOUT; k++) cnt_q[k] <= '0;
      end else begin
         s1_q  <= s1_d;
         out_q <= out_d;
         for (int k = 0; k < NOUT; k++) cnt_q[k] <= cnt_d[k];
      end
   end

   // map storage and readback; readback bypasses a same-edge write so it shows the new value
   always_ff @(posedge clk250_i) begin
      if (rst_i) begin
         map_rdata_q <= '0;
         for (int k = 0; k < NOUT; k++) map_q[k] <= def_entry(k);
      end else begin
         map_rdata_q <= !addr_ok ? '0 : map_wr_i ? map_data_i : map_q[addr];
         if (map_wr_i && addr_ok) map_q[addr] <= map_data_i;
      end
   end
endmodule

// File: tb/tb_anita_prog_trigger_map.sv
// tb_anita_prog_trigger_map: directed vector table plus randomised model comparison
module tb_anita_prog_trigger_map;
   logic        clk250_i = 1'b0;
   logic        rst_i = 1'b1, map_wr_i = 1'b0;
   logic [47:0] L1_i = '0;
   logic [31:0] mask_i = '0;
   logic [2:0]  stretch_i = '0;
   logic [5:0]  map_addr_i = '0, map_data_i = '0, map_rdata_o;
   logic [15:0] V_pol_phi_o, H_pol_phi_o;
   int total = 0, bad = 0;

   always #2 clk250_i = ~clk250_i;

   anita_prog_trigger_map #(.ADDR_BITS(6)) dut (
      .clk250_i(clk250_i), .rst_i(rst_i), .L1_i(L1_i), .mask_i(mask_i), .stretch_i(stretch_i),
      .map_wr_i(map_wr_i), .map_addr_i(map_addr_i), .map_data_i(map_data_i),
      .map_rdata_o(map_rdata_o), .V_pol_phi_o(V_pol_phi_o), .H_pol_phi_o(H_pol_phi_o)
   );

   typedef struct {
      logic        rst, wr;
      logic [47:0] l1;
      logic [31:0] mask;
      logic [2:0]  st;
      logic [5:0]  addr, data;
      logic [15:0] ev, eh;
      logic [5:0]  erd;
   } vec_t;
   typedef struct {
      logic [15:0] ev, eh;
      logic [5:0]  erd;
   } exp_t;

   vec_t vt[$];
   exp_t sb[$];
   logic [5:0]  m_map [32];
   logic [2:0]  m_cnt [32];
   logic [31:0] m_s1, m_out;
   logic [5:0]  m_rd;

   function automatic logic [47:0] b(int n);
      return 48'(1) << n;
   endfunction

   function automatic logic [5:0] def(int k);
      int p;
      p = k % 16;
      return 6'(8 + 4*(p/2) + p%2 + (k >= 16 ? 2 : 0));
   endfunction

   task automatic add(input logic rst, input logic wr, input logic [47:0] l1, input logic [31:0] mask,
                      input logic [2:0] st, input logic [5:0] addr, input logic [5:0] data,
                      input logic [15:0] ev, input logic [15:0] eh, input logic [5:0] erd);
      vt.push_back('{rst, wr, l1, mask, st, addr, data, ev, eh, erd});
   endtask

   task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic drive(input vec_t v, input exp_t e, input string nm);
      exp_t x;
      @(negedge clk250_i);
      rst_i = v.rst; map_wr_i = v.wr; L1_i = v.l1; mask_i = v.mask;
      stretch_i = v.st; map_addr_i = v.addr; map_data_i = v.data;
      sb.push_back(e);
      @(posedge clk250_i);
      #1;
      x = sb.pop_front();
      cmp({nm, " V"}, V_pol_phi_o, x.ev);
      cmp({nm, " H"}, H_pol_phi_o, x.eh);
      cmp({nm, " rdata"}, 16'(map_rdata_o), 16'(x.erd));
   endtask

   task automatic model_step(input vec_t v, output exp_t e);
      logic [31:0] ns1;
      if (v.rst) begin
         for (int k = 0; k < 32; k++) begin
            m_map[k] = def(k);
            m_cnt[k] = 3'd0;
         end
         m_s1 = '0; m_out = '0; m_rd = '0;
      end else begin
         for (int k = 0; k < 32; k++)
            ns1[k] = !v.mask[k] && (m_map[k] < 6'd48 ? v.l1[m_map[k]] : 1'b0);
         for (int k = 0; k < 32; k++) begin
            m_out[k] = m_s1[k] || (m_cnt[k] != 3'd0);
            m_cnt[k] = m_s1[k] ? v.st : (m_cnt[k] != 3'd0 ? m_cnt[k] - 3'd1 : 3'd0);
         end
         m_rd = (v.addr < 6'd32) ? (v.wr ? v.data : m_map[v.addr[4:0]]) : 6'd0;
         if (v.wr && v.addr < 6'd32) m_map[v.addr[4:0]] = v.data;
         m_s1 = ns1;
      end
      e = '{m_out[15:0], m_out[31:16], m_rd};
   endtask

   initial begin
      vec_t v;
      exp_t e;
      logic [47:0] all1;
      all1 = '1;
      // reset and default routing
      add(1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
      add(0, 0, b(8), 0, 0, 0, 0, 16'h0000, 16'h0000, 8);
      add(0, 0, 0, 0, 0, 0, 0, 16'h0001, 16'h0000, 8);
      add(0, 0, b(10), 0, 0, 0, 0, 16'h0000, 16'h0000, 8);
      add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0001, 8);
      add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 8);
      // map write, readback, out-of-range address and source
      add(0, 1, 0, 0, 0, 3, 47, 16'h0000, 16'h0000, 47);
      add(0, 0, b(47), 0, 0, 3, 0, 16'h0000, 16'h0000, 47);
      add(0, 0, 0, 0, 0, 3, 0, 16'h0008, 16'h0000, 47);
      add(0, 1, 0, 0, 0, 40, 5, 16'h0000, 16'h0000, 0);
      add(0, 0, 0, 0, 0, 8, 0, 16'h0000, 16'h0000, 24);
      add(0, 1, 0, 0, 0, 5, 60, 16'h0000, 16'h0000, 60);
      add(0, 0, all1, 0, 0, 5, 0, 16'h0000, 16'h0000, 60);
      add(0, 0, all1, 0, 0, 0, 0, 16'hFFDF, 16'hFFFF, 8);
      add(0, 0, 0, 0, 0, 0, 0, 16'hFFDF, 16'hFFFF, 8);
      add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 8);
      // stretch of 5: six output cycles
      add(0, 0, b(8), 0, 5, 0, 0, 16'h0000, 16'h0000, 8);
      for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 5, 0, 0, 16'h0001, 16'h0000, 8);
      add(0, 0, 0, 0, 5, 0, 0, 16'h0000, 16'h0000, 8);
      // retrigger mid-stretch; stretch_i change mid-stretch has no effect
      add(0, 0, b(8), 0, 5, 0, 0, 16'h0000, 16'h0000, 8);
      add(0, 0, 0, 0, 5, 0, 0, 16'h0001, 16'h0000, 8);
      add(0, 0, 0, 0, 5, 0, 0, 16'h0001, 16'h0000, 8);
      add(0, 0, b(8), 0, 5, 0, 0, 16'h0001, 16'h0000, 8);
      add(0, 0, 0, 0, 5, 0, 0, 16'h0001, 16'h0000, 8);
      add(0, 0, 0, 0, 5, 0, 0, 16'h0001, 16'h0000, 8);
      add(0, 0, 0, 0, 1, 0, 0, 16'h0001, 16'h0000, 8);
      add(0, 0, 0, 0, 1, 0, 0, 16'h0001, 16'h0000, 8);
      add(0, 0, 0, 0, 5, 0, 0, 16'h0001, 16'h0000, 8);
      add(0, 0, 0, 0, 5, 0, 0, 16'h0001, 16'h0000, 8);
      add(0, 0, 0, 0, 5, 0, 0, 16'h0000, 16'h0000, 8);
      // mask blocks V phi 0 only
      add(0, 0, b(8) | b(10), 1, 0, 0, 0, 16'h0000, 16'h0000, 8);
      add(0, 0, b(8) | b(10), 1, 0, 0, 0, 16'h0000, 16'h0001, 8);
      add(0, 0, b(8) | b(10), 1, 0, 0, 0, 16'h0000, 16'h0001, 8);
      add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0001, 8);
      add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 8);
      // mask raised mid-stretch lets the running stretch complete
      add(0, 0, b(8), 0, 3, 0, 0, 16'h0000, 16'h0000, 8);
      for (int i = 0; i < 4; i++) add(0, 0, b(8), 1, 3, 0, 0, 16'h0001, 16'h0000, 8);
      add(0, 0, b(8), 1, 3, 0, 0, 16'h0000, 16'h0000, 8);
      // reset during stretch beats a simultaneous write
      add(0, 0, b(8), 0, 5, 0, 0, 16'h0000, 16'h0000, 8);
      add(0, 0, 0, 0, 5, 0, 0, 16'h0001, 16'h0000, 8);
      add(0, 0, 0, 0, 5, 0, 0, 16'h0001, 16'h0000, 8);
      add(1, 1, 0, 0, 5, 0, 20, 16'h0000, 16'h0000, 0);
      add(0, 0, 0, 0, 5, 0, 0, 16'h0000, 16'h0000, 8);
      add(0, 0, 0, 0, 5, 3, 0, 16'h0000, 16'h0000, 13);
      foreach (vt[i]) begin
         e = '{vt[i].ev, vt[i].eh, vt[i].erd};
         drive(vt[i], e, $sformatf("vec%0d", i));
      end
      // randomised traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         v.rst  = (i == 0) || ($urandom_range(0, 59) == 0);
         v.wr   = ($urandom_range(0, 3) == 0);
         v.l1   = 48'({$urandom(), $urandom()}) & 48'({$urandom(), $urandom()});
         v.mask = ($urandom_range(0, 2) == 0) ? $urandom() : 32'd0;
         v.st   = 3'($urandom_range(0, 7));
         v.addr = 6'($urandom_range(0, 47));
         v.data = 6'($urandom_range(0, 63));
         model_step(v, e);
         drive(v, e, $sformatf("rnd%0d", i));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
